// File: rtl/timekeeper_pkg.sv
// rtl/timekeeper_pkg.sv - mode encodings and width helpers for timekeeper_core
package timekeeper_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTING = 2'd0,
    MODE_SET_MIN  = 2'd1,
    MODE_SET_HR   = 2'd2,
    MODE_CLR_SEC  = 2'd3
  } mode_e;

  localparam int ACCEL_W = 8;

  // Register width for a counter holding 0..modulus-1, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 2) ? $clog2(modulus) : 1;
  endfunction

  function automatic int half_of(input int modulus);
    return modulus / 2;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N counter with enable, synchronous clear and wrap flag
// o_wrap is combinational: high on the enabled step that returns the count to zero.
module mod_counter
  import timekeeper_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int WIDTH   = cnt_width(MODULUS)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    o_wrap  = i_en && (count_q == LAST);
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = o_wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/timekeeper_core.sv
// rtl/timekeeper_core.sv - h:m:s timekeeper with set acceleration, 12/24 h output, day pulse
// Optional alarm comparator built only when TIMEKEEPER_ALARM_EN is defined.
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int SECS_PER_MIN  = 60,
  parameter int MINS_PER_HOUR = 60,
  parameter int HOURS_PER_DAY = 24,
  parameter int ACCEL_COUNT   = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_1hz_stb,
  input  logic                                   i_slow_set_stb,
  input  logic                                   i_fast_set_stb,
  input  logic [1:0]                             i_mode,
  input  logic                                   i_fmt_12h,
  output logic [cnt_width(SECS_PER_MIN)-1:0]     o_seconds,
  output logic [cnt_width(MINS_PER_HOUR)-1:0]    o_minutes,
  output logic [cnt_width(HOURS_PER_DAY)-1:0]    o_hours,
  output logic                                   o_pm,
  output logic                                   o_clk_stb,
  output logic                                   o_day_stb
`ifdef TIMEKEEPER_ALARM_EN
  ,
  input  logic                                   i_alarm_arm,
  input  logic [cnt_width(HOURS_PER_DAY)-1:0]    i_alarm_hours,
  input  logic [cnt_width(MINS_PER_HOUR)-1:0]    i_alarm_minutes,
  input  logic                                   i_alarm_clr,
  output logic                                   o_alarm
`endif
);

  localparam int SW = cnt_width(SECS_PER_MIN);
  localparam int MW = cnt_width(MINS_PER_HOUR);
  localparam int HW = cnt_width(HOURS_PER_DAY);
  localparam logic [HW-1:0]      H2_V      = HW'(half_of(HOURS_PER_DAY));
  localparam logic [ACCEL_W-1:0] ACCEL_MAX = ACCEL_W'(ACCEL_COUNT);

  mode_e              mode;
  mode_e              mode_q;
  logic [ACCEL_W-1:0] accel_q;
  logic [ACCEL_W-1:0] accel_d;
  logic [ACCEL_W-1:0] accel_eff;
  logic               clk_stb_q;
  logic               clk_stb_d;
  logic               day_stb_q;
  logic               day_stb_d;
  logic               mode_chg;
  logic               set_mode;
  logic               act_stb;
  logic               counting;
  logic               sec_en;
  logic               sec_clr;
  logic               min_en;
  logic               hr_en;
  logic               sec_wrap;
  logic               min_wrap;
  logic               hr_wrap;
  logic [SW-1:0]      sec_cnt;
  logic [MW-1:0]      min_cnt;
  logic [HW-1:0]      hr_cnt;
  logic [HW-1:0]      hr_mod;

  assign mode = mode_e'(i_mode);

  // A mode change is treated as accel count 0 this cycle, so its first strobe is always slow.
  always_comb begin
    mode_chg  = (mode != mode_q);
    counting  = (mode == MODE_COUNTING);
    set_mode  = (mode == MODE_SET_MIN) || (mode == MODE_SET_HR);
    accel_eff = mode_chg ? '0 : accel_q;
    act_stb   = 1'b0;
    if (counting) begin
      act_stb = i_1hz_stb;
    end else if (set_mode) begin
      act_stb = (accel_eff < ACCEL_MAX) ? i_slow_set_stb : i_fast_set_stb;
    end
    accel_d = '0;
    if (set_mode) begin
      accel_d = (act_stb && (accel_eff < ACCEL_MAX)) ? accel_eff + 1'b1 : accel_eff;
    end
  end

  assign sec_en  = counting && act_stb;
  assign sec_clr = (mode == MODE_CLR_SEC);
  assign min_en  = ((mode == MODE_SET_MIN) && act_stb) || (counting && sec_wrap);
  assign hr_en   = ((mode == MODE_SET_HR) && act_stb) || (counting && min_wrap);

  always_comb begin
    clk_stb_d = sec_en || min_en || hr_en || (sec_clr && (sec_cnt != '0));
    day_stb_d = counting && hr_wrap;
  end

  mod_counter #(.MODULUS(SECS_PER_MIN), .WIDTH(SW)) u_sec (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (sec_en),
    .i_clr    (sec_clr),
    .o_count  (sec_cnt),
    .o_wrap   (sec_wrap)
  );

  mod_counter #(.MODULUS(MINS_PER_HOUR), .WIDTH(MW)) u_min (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (min_en),
    .i_clr    (1'b0),
    .o_count  (min_cnt),
    .o_wrap   (min_wrap)
  );

  mod_counter #(.MODULUS(HOURS_PER_DAY), .WIDTH(HW)) u_hr (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (hr_en),
    .i_clr    (1'b0),
    .o_count  (hr_cnt),
    .o_wrap   (hr_wrap)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q    <= MODE_COUNTING;
      accel_q   <= '0;
      clk_stb_q <= 1'b0;
      day_stb_q <= 1'b0;
    end else begin
      mode_q    <= mode;
      accel_q   <= accel_d;
      clk_stb_q <= clk_stb_d;
      day_stb_q <= day_stb_d;
    end
  end

  // 12 h display folds the hour into 1..H2, with 0 shown as H2.
  always_comb begin
    hr_mod  = (hr_cnt >= H2_V) ? hr_cnt - H2_V : hr_cnt;
    o_pm    = (hr_cnt >= H2_V);
    o_hours = hr_cnt;
    if (i_fmt_12h) begin
      o_hours = (hr_mod == '0) ? H2_V : hr_mod;
    end
  end

  assign o_seconds = sec_cnt;
  assign o_minutes = min_cnt;
  assign o_clk_stb = clk_stb_q;
  assign o_day_stb = day_stb_q;

`ifdef TIMEKEEPER_ALARM_EN
  logic          alarm_q;
  logic          alarm_d;
  logic          alarm_hit;
  logic [MW-1:0] min_next;
  logic [HW-1:0] hr_next;

  // Match against the post-strobe time: a seconds wrap lands exactly on hh:mm:00.
  always_comb begin
    min_next  = min_wrap ? '0 : min_cnt + 1'b1;
    hr_next   = hr_wrap ? '0 : (min_wrap ? hr_cnt + 1'b1 : hr_cnt);
    alarm_hit = sec_en && sec_wrap && i_alarm_arm &&
                (min_next == i_alarm_minutes) && (hr_next == i_alarm_hours);
    alarm_d   = alarm_q;
    if (alarm_hit) begin
      alarm_d = 1'b1;
    end
    if (i_alarm_clr || !i_alarm_arm) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign o_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
// tb/tb_timekeeper_core.sv - scoreboard bench for timekeeper_core
module tb_timekeeper_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hz = 1'b0;
  logic       slow = 1'b0;
  logic       fast = 1'b0;
  logic       fmt = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [5:0] sec;
  logic [5:0] mins;
  logic [4:0] hrs;
  logic       pm;
  logic       clk_stb;
  logic       day_stb;
`ifdef TIMEKEEPER_ALARM_EN
  logic       al_arm = 1'b0;
  logic       al_clr = 1'b0;
  logic [4:0] al_h = 5'd0;
  logic [5:0] al_m = 6'd0;
  logic       alarm;
`endif

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       pm;
    logic       cs;
    logic       ds;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_clk = 0;
  int   n_day = 0;
  int   ms = 0;
  int   mm = 0;
  int   mh = 0;
  int   macc = 0;
  logic [1:0] mprev = 2'd0;

  always #5 clk = ~clk;

  timekeeper_core dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_1hz_stb     (hz),
    .i_slow_set_stb(slow),
    .i_fast_set_stb(fast),
    .i_mode        (mode),
    .i_fmt_12h     (fmt),
    .o_seconds     (sec),
    .o_minutes     (mins),
    .o_hours       (hrs),
    .o_pm          (pm),
    .o_clk_stb     (clk_stb),
    .o_day_stb     (day_stb)
`ifdef TIMEKEEPER_ALARM_EN
    ,
    .i_alarm_arm    (al_arm),
    .i_alarm_hours  (al_h),
    .i_alarm_minutes(al_m),
    .i_alarm_clr    (al_clr),
    .o_alarm        (alarm)
`endif
  );

  function automatic logic [4:0] fmt_h(input int h, input logic f);
    if (!f) return 5'(h);
    return ((h % 12) == 0) ? 5'd12 : 5'(h % 12);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mm = 0; mh = 0; macc = 0; mprev = 2'd0;
  endtask

  // Reference clock behaviour for one cycle with the currently driven inputs.
  task automatic model_step();
    int   acc;
    logic st;
    logic cs;
    logic ds;
    exp_t e;
    cs  = 1'b0;
    ds  = 1'b0;
    acc = (mode != mprev) ? 0 : macc;
    case (mode)
      2'd0:       st = hz;
      2'd1, 2'd2: st = (acc < 4) ? slow : fast;
      default:    st = 1'b0;
    endcase
    if (mode == 2'd0 && st) begin
      cs = 1'b1;
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          mh++;
          if (mh == 24) begin
            mh = 0;
            ds = 1'b1;
          end
        end
      end
    end else if (mode == 2'd1 && st) begin
      cs = 1'b1;
      mm = (mm + 1) % 60;
    end else if (mode == 2'd2 && st) begin
      cs = 1'b1;
      mh = (mh + 1) % 24;
    end else if (mode == 2'd3) begin
      cs = (ms != 0);
      ms = 0;
    end
    if (mode == 2'd1 || mode == 2'd2) macc = (st && acc < 4) ? acc + 1 : acc;
    else macc = 0;
    mprev = mode;
    e.s  = 6'(ms);
    e.m  = 6'(mm);
    e.h  = fmt_h(mh, fmt);
    e.pm = (mh >= 12);
    e.cs = cs;
    e.ds = ds;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic h, input logic sl, input logic fa);
    exp_t e;
    exp_t o;
    hz   = h;
    slow = sl;
    fast = fa;
    model_step();
    @(posedge clk);
    #1;
    o = {sec, mins, hrs, pm, clk_stb, day_stb};
    if (clk_stb) n_clk++;
    if (day_stb) n_day++;
    e = sb.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL sb observed=%0d:%0d:%0d pm=%b cs=%b ds=%b expected=%0d:%0d:%0d pm=%b cs=%b ds=%b",
             o.h, o.m, o.s, o.pm, o.cs, o.ds, e.h, e.m, e.s, e.pm, e.cs, e.ds);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(mins), 0);
    chk("rst_hr24", int'(hrs), 0);
    chk("rst_pm", int'(pm), 0);
    chk("rst_stbs", int'({clk_stb, day_stb}), 0);
    fmt = 1'b1;
    #1;
    chk("rst_hr12", int'(hrs), 12);
    fmt = 1'b0;
    rst_n = 1'b1;

    // Full day of 1 Hz strobes.
    mode = 2'd0;
    for (int i = 0; i < 86400; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("day_count", n_day, 1);
    chk("day_clk_count", n_clk, 86400);
    chk("day_time", int'({hrs, mins, sec}), 0);

    // Preload 23:59:58 using simultaneous slow+fast strobes.
    mode = 2'd2;
    repeat (23) cyc(1'b0, 1'b1, 1'b1);
    mode = 2'd1;
    repeat (59) cyc(1'b0, 1'b1, 1'b1);
    mode = 2'd0;
    repeat (58) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_hr", int'(hrs), 23);
    chk("pre_min", int'(mins), 59);
    chk("pre_sec", int'(sec), 58);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap1_sec", int'(sec), 59);
    chk("wrap1_day", int'(day_stb), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap2_day", int'(day_stb), 1);
    chk("wrap2_time", int'({hrs, mins, sec}), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wrap3_day", int'(day_stb), 0);

    // SET_MINUTES from 10:59:30 with acceleration.
    mode = 2'd2;
    repeat (10) cyc(1'b0, 1'b1, 1'b1);
    mode = 2'd1;
    repeat (59) cyc(1'b0, 1'b1, 1'b1);
    mode = 2'd0;
    repeat (30) cyc(1'b1, 1'b0, 1'b0);
    mode = 2'd1;
    cyc(1'b0, 1'b1, 1'b0);
    chk("setm_min", int'(mins), 0);
    chk("setm_hr", int'(hrs), 10);
    chk("setm_sec", int'(sec), 30);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    chk("setm_4slow", int'(mins), 3);
    cyc(1'b0, 1'b1, 1'b0);
    chk("setm_slow_ignored", int'(mins), 3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("setm_hz_ignored", int'(mins), 3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("setm_fast", int'(mins), 4);

    // SET_HOURS -> COUNTING -> SET_HOURS restarts acceleration.
    mode = 2'd2;
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("seth_fast", int'(hrs), 15);
    mode = 2'd0;
    cyc(1'b0, 1'b0, 1'b0);
    mode = 2'd2;
    cyc(1'b0, 1'b0, 1'b1);
    chk("seth_fast_ignored", int'(hrs), 15);
    cyc(1'b0, 1'b1, 1'b0);
    chk("seth_slow_first", int'(hrs), 16);
    repeat (7) cyc(1'b0, 1'b1, 1'b1);
    chk("seth_23", int'(hrs), 23);
    cyc(1'b0, 1'b1, 1'b1);
    chk("seth_wrap_hr", int'(hrs), 0);
    chk("seth_wrap_noday", int'(day_stb), 0);

    // 12 h formatting.
    fmt = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("f12_h0", int'({hrs, pm}), (12 << 1) | 0);
    repeat (11) cyc(1'b0, 1'b1, 1'b1);
    chk("f12_h11", int'({hrs, pm}), (11 << 1) | 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("f12_h12", int'({hrs, pm}), (12 << 1) | 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("f12_h13", int'({hrs, pm}), (1 << 1) | 1);
    fmt = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("f24_h13", int'(hrs), 13);

    // CLEAR_SECONDS pulses once only.
    mode = 2'd3;
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_sec", int'(sec), 0);
    chk("clr_stb", int'(clk_stb), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("clr_stb_once", int'(clk_stb), 0);

    // Asynchronous reset in the middle of SET_MINUTES.
    mode = 2'd1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_time", int'({hrs, mins, sec}), 0);
    chk("arst_flags", int'({pm, clk_stb, day_stb}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 2'd0;
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    chk("arst_count", int'({hrs, mins, sec}), 5);

`ifdef TIMEKEEPER_ALARM_EN
    al_arm = 1'b1;
    al_h   = 5'd0;
    al_m   = 6'd1;
    repeat (54) cyc(1'b1, 1'b0, 1'b0);
    chk("alarm_before", int'(alarm), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("alarm_set", int'(alarm), 1);
    al_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("alarm_clr", int'(alarm), 0);
    al_clr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
